otter_mem_responder: RTL and testbench
======================================

OTTER_MEM_RESPONDER -- requirements
Module: otter_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word-address width (memory depth 2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, number of wait cycles inserted before each response.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_rden1  in  1  instruction-fetch read strobe.
- mem_addr1  in  32  fetch byte address.
- mem_rden2  in  1  data read strobe.
- mem_we2  in  1  data write strobe.
- mem_addr2  in  32  data byte address.
- mem_din2  in  32  store data, right-aligned.
- mem_size  in  2  access size: 00 byte, 01 half, 10 word.
- mem_sign  in  1  1 = zero-extend load (func[2]), 0 = sign-extend.
- mem_dout1  out  32  fetched instruction word.
- mem_dout2  out  32  load data, extended.
- mem_valid1  out  1  one-cycle fetch-response pulse.
- mem_valid2  out  1  one-cycle data-response pulse (loads and stores).
- mem_busy  out  1  request in flight or pending.
- mem_err  out  1  misaligned/out-of-range flag, qualifies the valid pulse.

Function
REQ-005 SHALL implement states IDLE, WAIT, RESP.
REQ-006 In IDLE, any strobe high at a rising edge SHALL latch address, data, size and sign, then go to WAIT (RESP if WAIT_CYCLES=0).
REQ-007 WAIT SHALL last exactly WAIT_CYCLES cycles via a down-counter, then go to RESP.
REQ-008 RESP SHALL last one cycle, asserting the matching mem_valid1/mem_valid2, then return to IDLE.
REQ-009 Latency: request sampled at edge k SHALL produce valid during the cycle after edge k+WAIT_CYCLES+1.
REQ-010 Port 2 SHALL have priority over port 1. If both are sampled together, port 1 SHALL be recorded as pending and served immediately after RESP, without returning through IDLE.
REQ-011 mem_rden2 and mem_we2 both high SHALL be treated as a write.
REQ-012 Strobes seen outside IDLE SHALL be ignored, except for setting the port-1 pending flag.
REQ-013 A store SHALL commit at the edge leaving RESP:
- byte: lane addr2[1:0].
- half: lanes {addr[1],0} and {addr[1],1}.
- word: all four lanes.
REQ-014 A load SHALL extract the addressed byte/half and extend it per mem_sign. A word load is passed through unchanged.
REQ-015 Error cases SHALL assert mem_err with valid, suppress the write, and drive the corresponding dout to 0:
- half with addr[0]=1.
- word with addr[1:0]≠0.
- mem_size=11.
- word address ≥ 2**ADDR_WIDTH.
- port 1 with addr1[1:0]≠0.
REQ-016 mem_dout1/mem_dout2 SHALL hold their last response value until the next response on the same port.
REQ-017 mem_busy SHALL be high in WAIT and RESP, and while port 1 is pending.

Reset
REQ-018 rst low SHALL immediately force IDLE, clear pending and the counter, and drive dout1=0, dout2=0, valid1=0, valid2=0, busy=0, err=0.
REQ-019 Reset mid-operation SHALL abort without committing a pending write; memory array contents SHALL NOT be reset.

Configuration
REQ-020 Macro OTTER_MEM_WAIT_STATE_EN:
- Defined: the WAIT state and counter exist, and WAIT_CYCLES is honoured.
- Undefined: no WAIT state or counter are built; IDLE goes directly to RESP, fixed latency = 1 wait-free cycle, and WAIT_CYCLES is ignored.

Structure
REQ-021 Package otter_mem_pkg SHALL hold:
- size enum: MEM_BYTE, MEM_HALF, MEM_WORD.
- state enum: IDLE, WAIT, RESP.
- constant WORD_W=32.
REQ-022 Sub-module otter_mem_align SHALL be purely combinational. It SHALL produce byte-enables, shifted store data, load extraction/extension and the misalign flag.

Verification
REQ-023 Word write, then read: WAIT_CYCLES=2, sw 0xDEADBEEF to 0x10, then lw 0x10 -> valid2 3 cycles after each sample, dout2=0xDEADBEEF, err=0.
REQ-024 Byte/half extension: word 0x8001F0FF at 0x20 -> lb 0x20 gives 0xFFFFFFFF; lbu gives 0x000000FF; lh 0x22 gives 0xFFFF8001; lhu 0x22 gives 0x00008001.
REQ-025 Simultaneous access: rden1 (0x0, holds 0x00000013) and rden2 in the same cycle -> valid2 first, then valid1 with dout1=0x00000013; busy stays high throughout.
REQ-026 Misalign: sw to 0x21 -> valid2 and err together, dout2=0, and word 0x20 unchanged on readback.
REQ-027 Reset mid-WAIT: sb 0xAA to 0x30 with rst pulsed low during WAIT -> all outputs 0 at once, and 0x30 unchanged on readback.
REQ-028 Macro undefined: lw 0x10 -> valid2 in the cycle after the next edge, regardless of WAIT_CYCLES=5.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER memory responder.
package otter_mem_pkg;

    localparam int WORD_W = 32;

    // Access size as carried on mem_size; 2'b11 is not a legal size.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    // Responder sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/otter_mem_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load extraction/extension and the misalignment flag.
module otter_mem_align
    import otter_mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] store_data,
    input  logic [WORD_W-1:0] load_word,
    input  logic              zero_ext,
    output logic [3:0]        byte_en,
    output logic [WORD_W-1:0] store_shifted,
    output logic [WORD_W-1:0] load_data,
    output logic              misalign
);

    mem_size_t         sz;
    logic [WORD_W-1:0] byte_word;
    logic [WORD_W-1:0] half_word;

    assign sz        = mem_size_t'(size);
    assign byte_word = load_word >> {addr_lo, 3'b000};
    assign half_word = load_word >> {addr_lo[1], 4'b0000};

    // Decode size into lane enables and extended load data.
    always_comb begin
        byte_en       = 4'b0000;
        store_shifted = '0;
        load_data     = '0;
        misalign      = 1'b0;
        case (sz)
            MEM_BYTE: begin
                byte_en       = 4'b0001 << addr_lo;
                store_shifted = {4{store_data[7:0]}};
                load_data     = zero_ext ? {24'b0, byte_word[7:0]}
                                         : {{24{byte_word[7]}}, byte_word[7:0]};
            end
            MEM_HALF: begin
                misalign      = addr_lo[0];
                byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_shifted = {2{store_data[15:0]}};
                load_data     = zero_ext ? {16'b0, half_word[15:0]}
                                         : {{16{half_word[15]}}, half_word[15:0]};
            end
            MEM_WORD: begin
                misalign      = (addr_lo != 2'b00);
                byte_en       = 4'b1111;
                store_shifted = store_data;
                load_data     = load_word;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/otter_mem_responder.sv
// Two-port OTTER memory responder with a single shared array.
// Optional wait states are enabled by defining OTTER_MEM_WAIT_STATE_EN;
// without it every access is answered with fixed one-cycle latency.
module otter_mem_responder
    import otter_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rden1,
    input  logic [31:0]       mem_addr1,
    input  logic              mem_rden2,
    input  logic              mem_we2,
    input  logic [31:0]       mem_addr2,
    input  logic [31:0]       mem_din2,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    output logic [WORD_W-1:0] mem_dout1,
    output logic [WORD_W-1:0] mem_dout2,
    output logic              mem_valid1,
    output logic              mem_valid2,
    output logic              mem_busy,
    output logic              mem_err
);

    // Protocol: a strobe is accepted only while the responder is IDLE (fetch
    // strobes seen while busy are queued as one pending fetch). Each accepted
    // request yields exactly one single-cycle valid pulse on its own port, with
    // mem_err qualifying that pulse; there is no back-pressure from the requester.

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_W-1:0]     mem [DEPTH];

    state_t                state_q;
    logic                  pend_q;
    logic [31:0]           pend_addr_q;
    logic                  req_port2_q;
    logic                  req_write_q;
    logic [31:0]           req_addr_q;
    logic [31:0]           req_din_q;
    logic [1:0]            req_size_q;
    logic                  req_sign_q;

    logic [ADDR_WIDTH-1:0] idx;
    logic [WORD_W-1:0]     rd_word;
    logic [3:0]            byte_en;
    logic [WORD_W-1:0]     store_shifted;
    logic [WORD_W-1:0]     load_data;
    logic                  misalign;
    logic                  out_of_range;
    logic                  rsp_err;
    logic                  port2_req;
    logic                  fetch_next;
    logic                  launch;
    logic                  commit;

`ifdef OTTER_MEM_WAIT_STATE_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
`else
    logic unused_wait_cycles;
    assign unused_wait_cycles = ^WAIT_CYCLES;
`endif

    assign idx          = req_addr_q[ADDR_WIDTH+1:2];
    assign out_of_range = |req_addr_q[31:ADDR_WIDTH+2];
    assign rd_word      = mem[idx];
    assign rsp_err      = misalign | out_of_range;
    assign port2_req    = mem_rden2 | mem_we2;
    assign fetch_next   = pend_q | mem_rden1;
    assign launch       = ((state_q == IDLE) && (port2_req || mem_rden1)) ||
                          ((state_q == RESP) && fetch_next);
    assign commit       = (state_q == RESP) && req_port2_q && req_write_q && !rsp_err;
    assign mem_busy     = (state_q != IDLE) || pend_q;

    otter_mem_align u_align (
        .size          (req_size_q),
        .addr_lo       (req_addr_q[1:0]),
        .store_data    (req_din_q),
        .load_word     (rd_word),
        .zero_ext      (req_sign_q),
        .byte_en       (byte_en),
        .store_shifted (store_shifted),
        .load_data     (load_data),
        .misalign      (misalign)
    );

    // Request sequencing, pending-fetch tracking and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            req_port2_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_din_q   <= '0;
            req_size_q  <= '0;
            req_sign_q  <= 1'b0;
            mem_dout1   <= '0;
            mem_dout2   <= '0;
            mem_valid1  <= 1'b0;
            mem_valid2  <= 1'b0;
            mem_err     <= 1'b0;
`ifdef OTTER_MEM_WAIT_STATE_EN
            cnt_q       <= '0;
`endif
        end else begin
            mem_valid1 <= 1'b0;
            mem_valid2 <= 1'b0;
            mem_err    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (port2_req) begin
                        req_port2_q <= 1'b1;
                        req_write_q <= mem_we2;
                        req_addr_q  <= mem_addr2;
                        req_din_q   <= mem_din2;
                        req_size_q  <= mem_size;
                        req_sign_q  <= mem_sign;
                        if (mem_rden1) begin
                            pend_q      <= 1'b1;
                            pend_addr_q <= mem_addr1;
                        end
                    end else if (mem_rden1) begin
                        req_port2_q <= 1'b0;
                        req_write_q <= 1'b0;
                        req_addr_q  <= mem_addr1;
                        req_size_q  <= MEM_WORD;
                        req_sign_q  <= 1'b0;
                    end
                end
`ifdef OTTER_MEM_WAIT_STATE_EN
                WAIT: begin
                    if (mem_rden1 && !pend_q) begin
                        pend_q      <= 1'b1;
                        pend_addr_q <= mem_addr1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
`endif
                RESP: begin
                    if (req_port2_q) begin
                        mem_valid2 <= 1'b1;
                        mem_err    <= rsp_err;
                        if (rsp_err) begin
                            mem_dout2 <= '0;
                        end else if (!req_write_q) begin
                            mem_dout2 <= load_data;
                        end
                    end else begin
                        mem_valid1 <= 1'b1;
                        mem_err    <= rsp_err;
                        mem_dout1  <= rsp_err ? '0 : rd_word;
                    end
                    // A queued (or just-arrived) fetch is served back to back.
                    if (fetch_next) begin
                        req_port2_q <= 1'b0;
                        req_write_q <= 1'b0;
                        req_addr_q  <= pend_q ? pend_addr_q : mem_addr1;
                        req_size_q  <= MEM_WORD;
                        req_sign_q  <= 1'b0;
                        pend_q      <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (launch) begin
`ifdef OTTER_MEM_WAIT_STATE_EN
                if (WAIT_CYCLES == 0) begin
                    state_q <= RESP;
                end else begin
                    state_q <= WAIT;
                    cnt_q   <= CNT_LOAD;
                end
`else
                state_q <= RESP;
`endif
            end
        end
    end

    // Store commit on the edge leaving RESP; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= store_shifted[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_otter_mem_responder.sv
// Scoreboard bench for otter_mem_responder: directed cases plus randomized
// traffic checked against a word-array reference model.
module tb_otter_mem_responder;

`ifdef OTTER_MEM_WAIT_STATE_EN
    localparam int W   = 2;
    localparam int LAT = W + 1;
`else
    localparam int W   = 5;
    localparam int LAT = 1;
`endif
    localparam int AW = 14;

    logic        clk;
    logic        rst;
    logic        mem_rden1;
    logic [31:0] mem_addr1;
    logic        mem_rden2;
    logic        mem_we2;
    logic [31:0] mem_addr2;
    logic [31:0] mem_din2;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_dout1;
    logic [31:0] mem_dout2;
    logic        mem_valid1;
    logic        mem_valid2;
    logic        mem_busy;
    logic        mem_err;

    otter_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rden1  (mem_rden1),
        .mem_addr1  (mem_addr1),
        .mem_rden2  (mem_rden2),
        .mem_we2    (mem_we2),
        .mem_addr2  (mem_addr2),
        .mem_din2   (mem_din2),
        .mem_size   (mem_size),
        .mem_sign   (mem_sign),
        .mem_dout1  (mem_dout1),
        .mem_dout2  (mem_dout2),
        .mem_valid1 (mem_valid1),
        .mem_valid2 (mem_valid2),
        .mem_busy   (mem_busy),
        .mem_err    (mem_err)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        port2;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
        logic [31:0] at_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: word array indexed by word address
    logic [31:0] model_mem [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int key;
        key = int'(a >> 2);
        if (model_mem.exists(key)) return model_mem[key];
        return 32'h0;
    endfunction

    function automatic logic model_err(input logic port2, input logic [31:0] a, input logic [1:0] sz);
        if ((a >> 2) >= 32'(2 ** AW)) return 1'b1;
        if (!port2) return (a % 4) != 0;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic zext);
        logic [31:0] w;
        logic [31:0] v;
        w = model_word(a);
        v = w;
        if (sz == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!zext && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * (a % 4))) & 32'hFFFF;
            if (!zext && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] w;
        w = model_word(a);
        if (sz == 2'd0) begin
            mask = 32'hFF << (8 * (a % 4));
            val  = (d & 32'hFF) << (8 * (a % 4));
        end else if (sz == 2'd1) begin
            mask = 32'hFFFF << (8 * (a % 4));
            val  = (d & 32'hFFFF) << (8 * (a % 4));
        end else begin
            mask = 32'hFFFF_FFFF;
            val  = d;
        end
        model_mem[int'(a >> 2)] = (w & ~mask) | (val & mask);
    endfunction

    // Driver: present one request for exactly one sampling edge
    task automatic issue(input logic f1, input logic [31:0] a1, input logic rd2, input logic we2,
                         input logic [31:0] a2, input logic [31:0] d2, input logic [1:0] sz,
                         input logic zext);
        exp_t        e;
        logic [31:0] k;
        @(posedge clk);
        #1;
        mem_rden1 = f1;
        mem_addr1 = a1;
        mem_rden2 = rd2;
        mem_we2   = we2;
        mem_addr2 = a2;
        mem_din2  = d2;
        mem_size  = sz;
        mem_sign  = zext;
        k = cyc + 1;
        if (rd2 || we2) begin
            e.port2    = 1'b1;
            e.err      = model_err(1'b1, a2, sz);
            e.at_cyc   = k + LAT;
            e.chk_data = 1'b1;
            e.data     = 32'h0;
            if (!e.err) begin
                if (we2) begin
                    model_store(a2, sz, d2);
                    e.chk_data = 1'b0;
                end else begin
                    e.data = model_load(a2, sz, zext);
                end
            end
            exp_q.push_back(e);
            k = k + LAT;
        end
        if (f1) begin
            e.port2    = 1'b0;
            e.err      = model_err(1'b0, a1, 2'd2);
            e.chk_data = 1'b1;
            e.data     = e.err ? 32'h0 : model_word(a1);
            e.at_cyc   = k + LAT;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mem_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("drain_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    // Monitor: pop and compare whenever a response pulse appears
    logic [31:0] last1 = 32'h0;
    logic [31:0] last2 = 32'h0;
    logic        last2_known = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last1 = 32'h0;
            last2 = 32'h0;
            last2_known = 1'b1;
        end else begin
            if (mem_valid1 && mem_valid2) check("both_valid", 32'h1, 32'h0);
            if (mem_valid1 || mem_valid2) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {mem_valid1, mem_valid2}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("port", 32'(mem_valid2), 32'(e.port2));
                    check("err", 32'(mem_err), 32'(e.err));
                    check("latency", cyc, e.at_cyc);
                    if (e.port2) begin
                        check("dout1_hold", mem_dout1, last1);
                        if (e.chk_data) begin
                            check("dout2", mem_dout2, e.data);
                            last2 = e.data;
                            last2_known = 1'b1;
                        end else begin
                            last2_known = 1'b0;
                        end
                    end else begin
                        if (last2_known) check("dout2_hold", mem_dout2, last2);
                        check("dout1", mem_dout1, e.data);
                        last1 = e.data;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d expectations outstanding", exp_q.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Stimulus sequence
    initial begin
        logic [31:0] a;
        logic [31:0] a1;
        logic [1:0]  sz;
        int          op;
        rst       = 1'b0;
        mem_rden1 = 1'b0;
        mem_addr1 = 32'h0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        mem_addr2 = 32'h0;
        mem_din2  = 32'h0;
        mem_size  = 2'b00;
        mem_sign  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout1", mem_dout1, 32'h0);
        check("rst_dout2", mem_dout2, 32'h0);
        check("rst_flags", {mem_valid1, mem_valid2, mem_busy, mem_err}, 32'h0);
        rst = 1'b1;

        // Word write then read
        issue(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        wait_done();
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        wait_done();

        // Byte/half extension
        issue(1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'h8001F0FF, 2'b10, 1'b0);
        wait_done();
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
        wait_done();
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b1);
        wait_done();
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0);
        wait_done();
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b1);
        wait_done();

        // Simultaneous fetch and data read; busy must not drop in between
        issue(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h00000013, 2'b10, 1'b0);
        wait_done();
        issue(1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        for (int i = 0; i < 2 * LAT - 1; i++) begin
            check("busy_dual", 32'(mem_busy), 32'h1);
            @(posedge clk);
            #1;
        end
        wait_done();

        // Misaligned store: error, no write
        issue(1'b0, 32'h0, 1'b0, 1'b1, 32'h21, 32'h12345678, 2'b10, 1'b0);
        wait_done();
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        wait_done();

        // Reset while a byte store is in flight
        issue(1'b0, 32'h0, 1'b0, 1'b1, 32'h30, 32'h11223344, 2'b10, 1'b0);
        wait_done();
        @(posedge clk);
        #1;
        mem_we2   = 1'b1;
        mem_addr2 = 32'h30;
        mem_din2  = 32'h000000AA;
        mem_size  = 2'b00;
        @(posedge clk);
        #1;
        mem_we2 = 1'b0;
        check("busy_inflight", 32'(mem_busy), 32'h1);
        rst = 1'b0;
        #1;
        check("midrst_dout1", mem_dout1, 32'h0);
        check("midrst_dout2", mem_dout2, 32'h0);
        check("midrst_flags", {mem_valid1, mem_valid2, mem_busy, mem_err}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 2'b00, 1'b1);
        wait_done();
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
        wait_done();

        // Randomized traffic over a pre-initialized region
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0);
            wait_done();
        end
        for (int i = 0; i < 120; i++) begin
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = 32'(2 ** AW) * 4 + 32'($urandom_range(0, 63));
            a1 = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 3) == 0) a1 = a1 + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) a1 = 32'(2 ** AW) * 4 + a1;
            sz = 2'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: issue(1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0, sz, 1'($urandom_range(0, 1)));
                3, 4, 5: issue(1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'b1, a, $urandom, sz, 1'b0);
                6, 7:    issue(1'b1, a1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
                default: issue(1'b1, a1, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, sz,
                               1'($urandom_range(0, 1)));
            endcase
            wait_done();
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
